// File: rtl/system_niosii_mul_pkg.sv
// Shared encodings for the Nios II sequential multiply path: operation codes,
// sequencer states and datapath widths.
package system_niosii_mul_pkg;

    localparam int MUL_W  = 32;
    localparam int HALF_W = 16;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULXUU = 2'b01;
    localparam logic [1:0] OP_MULXSU = 2'b10;
    localparam logic [1:0] OP_MULXSS = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE1,
        ST_CAP1,
        ST_ISSUE2,
        ST_CAP2,
        ST_FIX,
        ST_RESP
    } state_t;

    // Upper half of a word moved into the low half, zero-filled above.
    function automatic logic [MUL_W-1:0] hi_half(input logic [MUL_W-1:0] x);
        return {{HALF_W{1'b0}}, x[MUL_W-1:HALF_W]};
    endfunction

endpackage

// File: rtl/system_niosii_mul_hi_fix.sv
// Signed high-word correction: converts the unsigned high word of a*b into
// the MULXSU / MULXSS result by subtracting the sign-weighted operands.
module system_niosii_mul_hi_fix
    import system_niosii_mul_pkg::*;
(
    input  logic [1:0]       op,
    input  logic [MUL_W-1:0] a,
    input  logic [MUL_W-1:0] b,
    input  logic [MUL_W-1:0] hi_u,
    output logic [MUL_W-1:0] hi
);

    logic [MUL_W-1:0] corr_a;
    logic [MUL_W-1:0] corr_b;

    // A negative signed operand contributes -(other operand) * 2^32 to the product.
    always_comb begin
        corr_a = '0;
        corr_b = '0;
        if ((op == OP_MULXSU || op == OP_MULXSS) && a[MUL_W-1])
            corr_a = b;
        if (op == OP_MULXSS && b[MUL_W-1])
            corr_b = a;
        hi = hi_u - corr_a - corr_b;
    end

endmodule

// File: rtl/system_niosii_cpu_mult_seq.sv
// Multiply sequencer / result assembler driving the 16x16 partial-product cell.
// Define SYSTEM_NIOSII_MULX_EN to add the MULXUU/MULXSU/MULXSS high-word ops.
module system_niosii_cpu_mult_seq
    import system_niosii_mul_pkg::*;
#(
    parameter int CELL_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [MUL_W-1:0] req_src1,
    input  logic [MUL_W-1:0] req_src2,
    output logic             cell_en,
    output logic [MUL_W-1:0] cell_src1,
    output logic [MUL_W-1:0] cell_src2,
    input  logic [MUL_W-1:0] cell_p1,
    input  logic [MUL_W-1:0] cell_p2,
    input  logic [MUL_W-1:0] cell_p3,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [MUL_W-1:0] rsp_data,
    output logic             rsp_illegal
);

    localparam logic [1:0] LAT_LOAD = 2'(CELL_LAT - 1);

    state_t           state;
    logic [1:0]       lat_cnt;
    logic             op_ok;
    logic [MUL_W-1:0] mul_lo_p0;

    assign req_ready = (state == ST_IDLE) && !flush;

`ifdef SYSTEM_NIOSII_MULX_EN
    logic [1:0]            op_r;
    logic [MUL_W-1:0]      a_r;
    logic [MUL_W-1:0]      b_r;
    logic [MUL_W:0]        mid_p0;
    logic [MUL_W:0]        lo_sum_p0;
    logic [MUL_W-HALF_W:0] mid_hi_p1;
    logic                  carry_p1;
    logic [MUL_W-1:0]      hi_u_p2;
    logic [MUL_W-1:0]      hi_fix;

    assign op_ok     = 1'b1;
    assign mid_p0    = {1'b0, cell_p2} + {1'b0, cell_p3};
    assign lo_sum_p0 = {1'b0, cell_p1} + {1'b0, mid_p0[HALF_W-1:0], {HALF_W{1'b0}}};
    assign mul_lo_p0 = lo_sum_p0[MUL_W-1:0];

    // Operand and partial-sum capture; validity is implied by the FSM state.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && req_valid && req_ready) begin
            op_r <= req_op;
            a_r  <= req_src1;
            b_r  <= req_src2;
        end
        // Stage p1: keep the carry-extended mid upper bits and the low-word carry.
        if (state == ST_CAP1) begin
            mid_hi_p1 <= mid_p0[MUL_W:HALF_W];
            carry_p1  <= lo_sum_p0[MUL_W];
        end
        // Stage p2: unsigned high word, cell_p1 now holds a_hi*b_hi.
        if (state == ST_CAP2)
            hi_u_p2 <= cell_p1
                     + {{(HALF_W-1){1'b0}}, mid_hi_p1}
                     + {{(MUL_W-1){1'b0}}, carry_p1};
    end

    system_niosii_mul_hi_fix u_hi_fix (
        .op   (op_r),
        .a    (a_r),
        .b    (b_r),
        .hi_u (hi_u_p2),
        .hi   (hi_fix)
    );
`else
    assign op_ok     = (req_op == OP_MUL);
    assign mul_lo_p0 = cell_p1 + ((cell_p2 + cell_p3) << HALF_W);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            lat_cnt     <= '0;
            cell_en     <= 1'b0;
            cell_src1   <= '0;
            cell_src2   <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_illegal <= 1'b0;
        end else if (flush) begin
            state       <= ST_IDLE;
            cell_en     <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_illegal <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (op_ok) begin
                            state     <= ST_ISSUE1;
                            cell_en   <= 1'b1;
                            cell_src1 <= req_src1;
                            cell_src2 <= req_src2;
                            lat_cnt   <= LAT_LOAD;
                        end else begin
                            state       <= ST_RESP;
                            rsp_valid   <= 1'b1;
                            rsp_illegal <= 1'b1;
                            rsp_data    <= '0;
                        end
                    end
                end
                ST_ISSUE1: begin
                    if (lat_cnt != 2'd0) begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end else begin
                        state <= ST_CAP1;
`ifdef SYSTEM_NIOSII_MULX_EN
                        // MULX keeps the cell enabled: pass 2 overlaps the capture cycle.
                        if (op_r != OP_MUL) begin
                            cell_src1 <= hi_half(a_r);
                            cell_src2 <= hi_half(b_r);
                            lat_cnt   <= LAT_LOAD;
                        end else begin
                            cell_en <= 1'b0;
                        end
`else
                        cell_en <= 1'b0;
`endif
                    end
                end
                ST_CAP1: begin
`ifdef SYSTEM_NIOSII_MULX_EN
                    if (op_r == OP_MUL) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= mul_lo_p0;
                        state     <= ST_RESP;
                    end else if (lat_cnt != 2'd0) begin
                        lat_cnt <= lat_cnt - 2'd1;
                        state   <= ST_ISSUE2;
                    end else begin
                        cell_en <= 1'b0;
                        state   <= ST_CAP2;
                    end
`else
                    rsp_valid <= 1'b1;
                    rsp_data  <= mul_lo_p0;
                    state     <= ST_RESP;
`endif
                end
`ifdef SYSTEM_NIOSII_MULX_EN
                ST_ISSUE2: begin
                    if (lat_cnt != 2'd0) begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end else begin
                        cell_en <= 1'b0;
                        state   <= ST_CAP2;
                    end
                end
                ST_CAP2: state <= ST_FIX;
                ST_FIX: begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= hi_fix;
                    state     <= ST_RESP;
                end
`endif
                ST_RESP: begin
                    if (rsp_ready) begin
                        state       <= ST_IDLE;
                        rsp_valid   <= 1'b0;
                        rsp_illegal <= 1'b0;
                        rsp_data    <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
